// File: rtl/lvc_ahb_sram_pkg.sv
// Shared types for the AHB-to-SRAM slave: bus encodings, FSM states, response codes.
package lvc_ahb_sram_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    RESP_OKAY  = 2'b00,
    RESP_ERROR = 2'b01,
    RESP_RETRY = 2'b10,
    RESP_SPLIT = 2'b11
  } hresp_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'd0,
    HSIZE_HALF  = 3'd1,
    HSIZE_WORD  = 3'd2,
    HSIZE_DWORD = 3'd3,
    HSIZE_4W    = 3'd4,
    HSIZE_8W    = 3'd5,
    HSIZE_16W   = 3'd6,
    HSIZE_32W   = 3'd7
  } hsize_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_WR_STALL,
    ST_ERR1,
    ST_ERR2
  } st_e;

  localparam hresp_e HRESP_OKAY  = RESP_OKAY;
  localparam hresp_e HRESP_ERROR = RESP_ERROR;

endpackage

// File: rtl/lvc_ahb_sram_slave_if.sv
// AHB slave bus bundle plus the SRAM macro port, seen from the slave or the bus/RAM side.
interface lvc_ahb_sram_slave_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic                  hsel;
  logic [ADDR_WIDTH-1:0] haddr;
  logic [1:0]            htrans;
  logic [2:0]            hsize;
  logic [2:0]            hburst;
  logic                  hwrite;
  logic [DATA_WIDTH-1:0] hwdata;
  logic                  hready_in;
  logic                  hreadyout;
  logic [1:0]            hresp;
  logic [DATA_WIDTH-1:0] hrdata;

  logic                  sram_cs;
  logic                  sram_we;
  logic [ADDR_WIDTH-3:0] sram_addr;
  logic [3:0]            sram_be;
  logic [DATA_WIDTH-1:0] sram_wdata;
  logic [DATA_WIDTH-1:0] sram_rdata;

  modport slave (
    input  hsel, haddr, htrans, hsize, hburst, hwrite, hwdata, hready_in, sram_rdata,
    output hreadyout, hresp, hrdata, sram_cs, sram_we, sram_addr, sram_be, sram_wdata
  );

  modport master (
    output hsel, haddr, htrans, hsize, hburst, hwrite, hwdata, hready_in, sram_rdata,
    input  hreadyout, hresp, hrdata, sram_cs, sram_we, sram_addr, sram_be, sram_wdata
  );
endinterface

// File: rtl/lvc_ahb_sram_be_gen.sv
// Address-phase decode of size/alignment into SRAM byte lanes and a legality flag.
module lvc_ahb_sram_be_gen
  import lvc_ahb_sram_pkg::*;
(
  input  logic [1:0] addr_lo,
  input  logic [2:0] size,
  output logic [3:0] be,
  output logic       legal
);

  always_comb begin
    be    = 4'b0000;
    legal = 1'b0;
    case (hsize_e'(size))
      HSIZE_BYTE: begin
        be    = 4'b0001 << addr_lo;
        legal = 1'b1;
      end
      HSIZE_HALF: begin
        be    = 4'b0011 << {addr_lo[1], 1'b0};
        legal = ~addr_lo[0];
      end
      HSIZE_WORD: begin
        be    = 4'b1111;
        legal = (addr_lo == 2'b00);
      end
      default: begin
        be    = 4'b0000;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/lvc_ahb_sram_slave.sv
// AHB slave fronting a single-port synchronous SRAM: zero-wait reads/writes, one wait
// state on a write-then-read port collision, two-cycle ERROR on illegal size/alignment.
module lvc_ahb_sram_slave
  import lvc_ahb_sram_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input logic                 hclk,
  input logic                 hreset,
  lvc_ahb_sram_slave_if.slave bus
);

  localparam int WAW = ADDR_WIDTH - 2;

  st_e            state_q, state_d;
  logic [WAW-1:0] addr_q, addr_d;
  logic [3:0]     be_q, be_d;

  logic [3:0]     be;
  logic           legal;
  htrans_e        trans;
  logic           req, collide, can_acc, acc;

  logic                  hreadyout_c;
  hresp_e                hresp_c;
  logic [DATA_WIDTH-1:0] hrdata_c;
  logic                  cs_c, we_c;
  logic [WAW-1:0]        sram_addr_c;
  logic [3:0]            sram_be_c;
  logic [DATA_WIDTH-1:0] sram_wdata_c;

  logic unused_hburst;
  assign unused_hburst = ^bus.hburst;

  lvc_ahb_sram_be_gen u_be_gen (
    .addr_lo (bus.haddr[1:0]),
    .size    (bus.hsize),
    .be      (be),
    .legal   (legal)
  );

  assign trans = htrans_e'(bus.htrans);
  assign req   = bus.hsel & ((trans == HTRANS_NONSEQ) | (trans == HTRANS_SEQ));

  // A read arriving during a write data phase would need the port twice this cycle.
  assign collide = (state_q == ST_WR) & req & ~bus.hwrite;

  always_comb begin
    can_acc = 1'b0;
    case (state_q)
      ST_IDLE, ST_RD, ST_WR_STALL, ST_ERR2: can_acc = 1'b1;
      ST_WR:                                can_acc = ~collide;
      default:                              can_acc = 1'b0;
    endcase
  end

  assign acc = can_acc & req & bus.hready_in;

  always_comb begin
    state_d      = ST_IDLE;
    addr_d       = addr_q;
    be_d         = be_q;
    hreadyout_c  = 1'b1;
    hresp_c      = HRESP_OKAY;
    hrdata_c     = '0;
    cs_c         = 1'b0;
    we_c         = 1'b0;
    sram_addr_c  = '0;
    sram_be_c    = 4'b0000;
    sram_wdata_c = '0;

    // Data phase of the transfer accepted last cycle.
    case (state_q)
      ST_RD: hrdata_c = bus.sram_rdata;
      ST_WR: begin
        cs_c         = 1'b1;
        we_c         = 1'b1;
        sram_addr_c  = addr_q;
        sram_be_c    = be_q;
        sram_wdata_c = bus.hwdata;
        if (collide) begin
          hreadyout_c = 1'b0;
          state_d     = ST_WR_STALL;
        end
      end
      ST_ERR1: begin
        hreadyout_c = 1'b0;
        hresp_c     = HRESP_ERROR;
        state_d     = ST_ERR2;
      end
      ST_ERR2: hresp_c = HRESP_ERROR;
      default: ;
    endcase

    // Address phase; a read goes to the RAM now so data is back next cycle.
    if (acc) begin
      addr_d = bus.haddr[ADDR_WIDTH-1:2];
      be_d   = be;
      if (!legal) begin
        state_d = ST_ERR1;
      end else if (bus.hwrite) begin
        state_d = ST_WR;
      end else begin
        state_d     = ST_RD;
        cs_c        = 1'b1;
        we_c        = 1'b0;
        sram_addr_c = bus.haddr[ADDR_WIDTH-1:2];
        sram_be_c   = be;
      end
    end

    // Outputs sit at their idle values for as long as reset is held.
    if (hreset) begin
      hreadyout_c  = 1'b1;
      hresp_c      = HRESP_OKAY;
      hrdata_c     = '0;
      cs_c         = 1'b0;
      we_c         = 1'b0;
      sram_addr_c  = '0;
      sram_be_c    = 4'b0000;
      sram_wdata_c = '0;
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      be_q    <= 4'b0000;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
    end
  end

  assign bus.hreadyout  = hreadyout_c;
  assign bus.hresp      = hresp_c;
  assign bus.hrdata     = hrdata_c;
  assign bus.sram_cs    = cs_c;
  assign bus.sram_we    = we_c;
  assign bus.sram_addr  = sram_addr_c;
  assign bus.sram_be    = sram_be_c;
  assign bus.sram_wdata = sram_wdata_c;

endmodule

// File: tb/tb_lvc_ahb_sram_slave.sv
// Directed bench for lvc_ahb_sram_slave with a behavioural SRAM and hand-computed expectations.
module tb_lvc_ahb_sram_slave;
  import lvc_ahb_sram_pkg::*;

  logic hclk   = 1'b0;
  logic hreset = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  lvc_ahb_sram_slave_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();

  lvc_ahb_sram_slave #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (bus)
  );

  always #5 hclk = ~hclk;

  // Single slave on the bus: bus HREADY is this slave's HREADYOUT.
  assign bus.hready_in = bus.hreadyout;

  logic [31:0] mem [0:(1<<14)-1];
  logic [31:0] rdata_q = '0;
  assign bus.sram_rdata = rdata_q;

  always @(posedge hclk) begin
    if (bus.sram_cs) begin
      if (bus.sram_we) begin
        for (int b = 0; b < 4; b++)
          if (bus.sram_be[b]) mem[bus.sram_addr][8*b +: 8] <= bus.sram_wdata[8*b +: 8];
      end else begin
        rdata_q <= mem[bus.sram_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic aph(input logic sel, input logic [1:0] tr, input logic [15:0] a,
                     input logic [2:0] sz, input logic wr);
    bus.hsel   = sel;
    bus.htrans = tr;
    bus.haddr  = a;
    bus.hsize  = sz;
    bus.hwrite = wr;
  endtask

  task automatic idle();
    aph(1'b1, HTRANS_IDLE, 16'h0000, 3'd2, 1'b0);
  endtask

  task automatic nxt();
    @(posedge hclk);
    #1;
  endtask

  task automatic smp();
    @(negedge hclk);
  endtask

  initial begin
    bus.hburst = 3'b000;
    bus.hwdata = '0;
    // live read request while reset is held must not reach the RAM
    aph(1'b1, HTRANS_NONSEQ, 16'h0010, 3'd2, 1'b0);
    repeat (2) @(posedge hclk);
    smp();
    chk("rst_hreadyout", bus.hreadyout, 32'd1);
    chk("rst_hresp", bus.hresp, 32'd0);
    chk("rst_hrdata", bus.hrdata, 32'd0);
    chk("rst_cs", bus.sram_cs, 32'd0);
    chk("rst_we", bus.sram_we, 32'd0);
    chk("rst_addr", bus.sram_addr, 32'd0);
    chk("rst_be", bus.sram_be, 32'd0);
    chk("rst_wdata", bus.sram_wdata, 32'd0);
    nxt(); hreset = 1'b0; idle();

    // word write 0x10 <= DEADBEEF, read back two cycles later
    nxt(); aph(1'b1, HTRANS_NONSEQ, 16'h0010, 3'd2, 1'b1); smp();
    chk("w1_aph_cs", bus.sram_cs, 32'd0);
    chk("w1_aph_rdy", bus.hreadyout, 32'd1);
    nxt(); idle(); bus.hwdata = 32'hDEAD_BEEF; smp();
    chk("w1_cs", bus.sram_cs, 32'd1);
    chk("w1_we", bus.sram_we, 32'd1);
    chk("w1_addr", bus.sram_addr, 32'h4);
    chk("w1_be", bus.sram_be, 32'hF);
    chk("w1_wdata", bus.sram_wdata, 32'hDEAD_BEEF);
    chk("w1_rdy", bus.hreadyout, 32'd1);
    nxt(); aph(1'b1, HTRANS_NONSEQ, 16'h0010, 3'd2, 1'b0); bus.hwdata = '0; smp();
    chk("r1_cs", bus.sram_cs, 32'd1);
    chk("r1_we", bus.sram_we, 32'd0);
    chk("r1_addr", bus.sram_addr, 32'h4);
    nxt(); idle(); smp();
    chk("r1_hrdata", bus.hrdata, 32'hDEAD_BEEF);
    chk("r1_rdy", bus.hreadyout, 32'd1);

    // byte write to lane 3, then merged word read
    nxt(); aph(1'b1, HTRANS_NONSEQ, 16'h0013, 3'd0, 1'b1); smp();
    nxt(); idle(); bus.hwdata = 32'hAA00_0000; smp();
    chk("wb_we", bus.sram_we, 32'd1);
    chk("wb_be", bus.sram_be, 32'h8);
    chk("wb_addr", bus.sram_addr, 32'h4);
    nxt(); aph(1'b1, HTRANS_NONSEQ, 16'h0010, 3'd2, 1'b0); bus.hwdata = '0; smp();
    nxt(); idle(); smp();
    chk("rb_hrdata", bus.hrdata, 32'hAAAD_BEEF);

    // write immediately followed by read of the same word: one wait state
    nxt(); aph(1'b1, HTRANS_NONSEQ, 16'h0020, 3'd2, 1'b1); smp();
    nxt(); aph(1'b1, HTRANS_NONSEQ, 16'h0020, 3'd2, 1'b0); bus.hwdata = 32'h1234_5678; smp();
    chk("col_rdy0", bus.hreadyout, 32'd0);
    chk("col_we", bus.sram_we, 32'd1);
    chk("col_waddr", bus.sram_addr, 32'h8);
    chk("col_wdata", bus.sram_wdata, 32'h1234_5678);
    nxt(); smp();
    chk("stall_rdy", bus.hreadyout, 32'd1);
    chk("stall_cs", bus.sram_cs, 32'd1);
    chk("stall_we", bus.sram_we, 32'd0);
    chk("stall_addr", bus.sram_addr, 32'h8);
    nxt(); idle(); bus.hwdata = '0; smp();
    chk("col_hrdata", bus.hrdata, 32'h1234_5678);
    chk("col_rdy", bus.hreadyout, 32'd1);

    // write followed by write: zero wait
    nxt(); aph(1'b1, HTRANS_NONSEQ, 16'h0030, 3'd2, 1'b1); smp();
    nxt(); aph(1'b1, HTRANS_NONSEQ, 16'h0034, 3'd2, 1'b1); bus.hwdata = 32'hCAFE_0001; smp();
    chk("ww_rdy", bus.hreadyout, 32'd1);
    chk("ww_addr0", bus.sram_addr, 32'hC);
    nxt(); idle(); bus.hwdata = 32'hCAFE_0002; smp();
    chk("ww_we1", bus.sram_we, 32'd1);
    chk("ww_addr1", bus.sram_addr, 32'hD);
    chk("ww_wdata1", bus.sram_wdata, 32'hCAFE_0002);
    nxt(); aph(1'b1, HTRANS_NONSEQ, 16'h0034, 3'd2, 1'b0); bus.hwdata = '0; smp();
    nxt(); idle(); smp();
    chk("ww_hrdata", bus.hrdata, 32'hCAFE_0002);

    // misaligned halfword: two-cycle ERROR, next transfer accepted in ERR2
    nxt(); aph(1'b1, HTRANS_NONSEQ, 16'h0021, 3'd1, 1'b0); smp();
    chk("eh_aph_cs", bus.sram_cs, 32'd0);
    chk("eh_aph_resp", bus.hresp, 32'd0);
    nxt(); idle(); smp();
    chk("eh1_resp", bus.hresp, 32'd1);
    chk("eh1_rdy", bus.hreadyout, 32'd0);
    chk("eh1_cs", bus.sram_cs, 32'd0);
    nxt(); aph(1'b1, HTRANS_NONSEQ, 16'h0020, 3'd2, 1'b0); smp();
    chk("eh2_resp", bus.hresp, 32'd1);
    chk("eh2_rdy", bus.hreadyout, 32'd1);
    chk("eh2_cs", bus.sram_cs, 32'd1);
    nxt(); idle(); smp();
    chk("eh_next_resp", bus.hresp, 32'd0);
    chk("eh_next_hrdata", bus.hrdata, 32'h1234_5678);

    // 64-bit write: ERROR, RAM untouched even with write data on the bus
    nxt(); aph(1'b1, HTRANS_NONSEQ, 16'h0000, 3'd3, 1'b1); smp();
    chk("ed_aph_cs", bus.sram_cs, 32'd0);
    nxt(); idle(); bus.hwdata = 32'hFFFF_FFFF; smp();
    chk("ed1_resp", bus.hresp, 32'd1);
    chk("ed1_rdy", bus.hreadyout, 32'd0);
    chk("ed1_cs", bus.sram_cs, 32'd0);
    nxt(); smp();
    chk("ed2_resp", bus.hresp, 32'd1);
    chk("ed2_rdy", bus.hreadyout, 32'd1);
    chk("ed2_cs", bus.sram_cs, 32'd0);

    // BUSY / IDLE / deselected: OKAY, zero wait, no RAM strobe
    nxt(); aph(1'b1, HTRANS_BUSY, 16'h0010, 3'd2, 1'b0); bus.hwdata = '0; smp();
    chk("busy_cs", bus.sram_cs, 32'd0);
    chk("busy_rdy", bus.hreadyout, 32'd1);
    chk("busy_resp", bus.hresp, 32'd0);
    nxt(); idle(); smp();
    chk("idle_cs", bus.sram_cs, 32'd0);
    nxt(); aph(1'b0, HTRANS_NONSEQ, 16'h0010, 3'd2, 1'b0); smp();
    chk("nsel_cs", bus.sram_cs, 32'd0);
    nxt(); idle(); smp();
    chk("nsel_hrdata", bus.hrdata, 32'd0);

    // reset during a write data phase drops the write
    nxt(); aph(1'b1, HTRANS_NONSEQ, 16'h0010, 3'd2, 1'b1); smp();
    nxt(); idle(); bus.hwdata = 32'h5555_5555; smp();
    chk("rw_pre_we", bus.sram_we, 32'd1);
    #1 hreset = 1'b1;
    #1;
    chk("rw_we", bus.sram_we, 32'd0);
    chk("rw_cs", bus.sram_cs, 32'd0);
    chk("rw_wdata", bus.sram_wdata, 32'd0);
    chk("rw_rdy", bus.hreadyout, 32'd1);
    nxt(); hreset = 1'b0; bus.hwdata = '0;
    aph(1'b1, HTRANS_NONSEQ, 16'h0010, 3'd2, 1'b0); smp();
    chk("rw_rd_cs", bus.sram_cs, 32'd1);
    nxt(); idle(); smp();
    chk("rw_old_data", bus.hrdata, 32'hAAAD_BEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
